// File: rtl/spi_shift_engine.sv
// SPI master shift engine: pops TX FIFO words, serialises them on MOSI with
// programmable CPOL/CPHA/bit order/length, and pushes assembled MISO words.
module spi_shift_engine #(
   parameter int DATA_WIDTH = 32,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  dord,
   input  logic [4:0]            datalen,
   input  logic [DIV_WIDTH-1:0]  clkdiv,
   input  logic [DATA_WIDTH-1:0] tdata,
   input  logic                  tfifo_empty,
   output logic                  tfifo_ren,
   output logic [DATA_WIDTH-1:0] rdata,
   input  logic                  rfifo_full,
   output logic                  rfifo_wen,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   output logic                  ss_n,
   output logic                  busy,
   output logic                  rx_overrun
);

   typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TAIL, S_GAP} state_t;

   state_t                state_q, state_d;
   logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d;
   logic [6:0]            edge_q, edge_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
   logic [4:0]            len_q, len_d;
   logic                  cpol_q, cpol_d, cpha_q, cpha_d, dord_q, dord_d;
   logic                  sclk_q, sclk_d, mosi_q, mosi_d, ss_n_q, ss_n_d;
   logic                  ren_q, ren_d, wen_q, wen_d, ovr_q, ovr_d, busy_q, busy_d;
   logic [DATA_WIDTH-1:0] aligned;
   logic                  sample_edge;

   function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb_first);
      return lsb_first ? v[0] : v[DATA_WIDTH-1];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] v, input logic lsb_first);
      return lsb_first ? (v >> 1) : (v << 1);
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      edge_d  = edge_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      len_d   = len_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      dord_d  = dord_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      ss_n_d  = ss_n_q;
      ren_d   = 1'b0;
      wen_d   = 1'b0;
      ovr_d   = 1'b0;
      // MSB-first frames are pre-shifted so bit N-1 sits at the register top.
      aligned = dord ? tdata : (tdata << (DATA_WIDTH - 1 - int'(datalen)));
      sample_edge = ~edge_q[0] ^ cpha_q;

      case (state_q)
         S_IDLE: begin
            sclk_d = cpol;
            ss_n_d = 1'b1;
            if (enable && !tfifo_empty) begin
               ren_d   = 1'b1;
               cpol_d  = cpol;
               cpha_d  = cpha;
               dord_d  = dord;
               len_d   = datalen;
               div_d   = clkdiv;
               cnt_d   = clkdiv;
               rx_d    = '0;
               ss_n_d  = 1'b0;
               state_d = S_LEAD;
               if (!cpha) begin
                  mosi_d = head_bit(aligned, dord);
                  tx_d   = advance(aligned, dord);
               end else begin
                  tx_d   = aligned;
               end
            end
         end
         S_LEAD: begin
            if (cnt_q == '0) begin
               cnt_d   = div_q;
               edge_d  = {1'b0, len_q, 1'b0} + 7'd2;
               state_d = S_SHIFT;
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         S_SHIFT: begin
            if (cnt_q == '0) begin
               cnt_d  = div_q;
               sclk_d = ~sclk_q;
               edge_d = edge_q - 7'd1;
               if (sample_edge) begin
                  if (dord_q) begin
                     rx_d        = rx_q >> 1;
                     rx_d[len_q] = miso;
                  end else begin
                     rx_d = {rx_q[DATA_WIDTH-2:0], miso};
                  end
               end else if (edge_q != 7'd1) begin
                  mosi_d = head_bit(tx_q, dord_q);
                  tx_d   = advance(tx_q, dord_q);
               end
               if (edge_q == 7'd1) state_d = S_TAIL;
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         S_TAIL: begin
            if (cnt_q == '0) begin
               cnt_d   = div_q;
               ss_n_d  = 1'b1;
               state_d = S_GAP;
               if (!rfifo_full) begin
                  wen_d   = 1'b1;
                  rdata_d = rx_q;
               end else begin
                  ovr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - DIV_WIDTH'(1);
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         edge_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         len_q   <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         dord_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         ss_n_q  <= 1'b1;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         len_q   <= len_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         dord_q  <= dord_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         ss_n_q  <= ss_n_d;
         ren_q   <= ren_d;
         wen_q   <= wen_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
      end
   end

   assign tfifo_ren  = ren_q;
   assign rfifo_wen  = wen_q;
   assign rdata      = rdata_q;
   assign sclk       = sclk_q;
   assign mosi       = mosi_q;
   assign ss_n       = ss_n_q;
   assign busy       = busy_q;
   assign rx_overrun = ovr_q;

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- SPI master serializer/deserializer that sits directly downstream of the SPI data/FIFO block.
- Pops words from the transmit FIFO head and shifts them out on MOSI with the configured clock polarity, phase, bit order and length.
- Samples MISO and pushes each assembled received word into the receive FIFO.
- Generates SCLK from the system clock via a programmable divider and drives a single active-low slave select.

Parameters:
- DATA_WIDTH, 32, width of the FIFO words and of the maximum frame.
- DIV_WIDTH, 8, width of the clock-divider field.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  engine enable; sampled only in IDLE.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- dord  in  1  0 = MSB first, 1 = LSB first.
- datalen  in  5  frame length minus 1 (N = datalen+1 bits).
- clkdiv  in  DIV_WIDTH  SCLK half-period minus 1, in clk cycles.
- tdata  in  DATA_WIDTH  transmit FIFO head word (first-word-fall-through).
- tfifo_empty  in  1  transmit FIFO empty.
- tfifo_ren  out  1  one-cycle pop pulse.
- rdata  out  DATA_WIDTH  received word, right-justified, upper bits zero.
- rfifo_full  in  1  receive FIFO full.
- rfifo_wen  out  1  one-cycle push pulse; rdata is valid in the same cycle.
- sclk  out  1  SPI clock.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- ss_n  out  1  slave select, active low.
- busy  out  1  high in any state other than IDLE.
- rx_overrun  out  1  one-cycle pulse when a received word is dropped.

Behaviour:
- Reset (async, immediate, including mid-frame): state=IDLE, sclk=0, mosi=0, ss_n=1, tfifo_ren=0, rfifo_wen=0, busy=0, rdata=0, rx_overrun=0, all counters 0.
- All outputs are registered.
- Half-period H = clkdiv+1 clk cycles, counted by a down-counter reloaded at each SCLK edge.
- FSM states: IDLE, LEAD, SHIFT, TAIL, GAP.
- IDLE:
  - ss_n=1, sclk follows cpol.
  - When enable=1 and tfifo_empty=0: assert tfifo_ren for exactly 1 cycle.
  - In that same cycle, latch tdata into the shift register and latch cpol, cpha, dord, datalen and clkdiv; these stay frozen for the whole frame.
  - Then go to LEAD.
- LEAD:
  - ss_n=0.
  - If cpha=0, mosi presents the first bit at LEAD entry.
  - Hold for H cycles, then go to SHIFT.
- SHIFT:
  - Toggle sclk every H cycles, exactly 2N edges. An edge counter counts 2N down to 0.
  - Sample edge: shift miso into the receive register.
  - Shift edge: present the next bit on mosi.
  - cpha=0: leading edges sample, trailing edges shift. No shift after the final trailing edge.
  - cpha=1: leading edges shift (first leading edge presents bit 0 of the sequence), trailing edges sample.
- Bit order:
  - dord=0: transmit sequence is tdata[N-1] down to tdata[0]; received bits enter at bit 0, shifting left, so the first received bit ends at bit N-1.
  - dord=1: transmit sequence is tdata[0] up to tdata[N-1]; the first received bit ends at bit 0.
  - Bits above N-1 of tdata are ignored; rdata[DATA_WIDTH-1:N] = 0.
- TAIL:
  - sclk at cpol, ss_n still 0, hold H cycles.
  - On exit, if rfifo_full=0: pulse rfifo_wen and update rdata.
  - If rfifo_full=1: no push, pulse rx_overrun, rdata unchanged. The word is dropped.
  - Then go to GAP.
- GAP: ss_n=1 for H cycles, then go to IDLE. Back-to-back frames are therefore separated by at least H+1 cycles of ss_n high.
- enable deasserted mid-frame: the current frame completes normally, including the push. No new pop occurs.
- tfifo_empty changes outside IDLE are ignored.
- datalen=0: single-bit frame, 2 SCLK edges.
- datalen=31: full 32-bit frame.
- clkdiv counter wrap: a value of 0 gives H=1; the maximum value gives H=2^DIV_WIDTH.
- tfifo_ren and rfifo_wen never assert in the same cycle.

Test Plan:
- cpol=0, cpha=0, dord=0, datalen=3, clkdiv=0, tdata=0x0000000A, miso tied to mosi:
  - tfifo_ren pulses once; mosi sampled on rising edges = 1,0,1,0; sclk toggles exactly 8 times.
  - rfifo_wen pulses once with rdata=0x0000000A; ss_n low for the whole frame.
- Same as above but dord=1, tdata=0x0000000B: mosi sequence = 1,1,0,1; rdata=0x0000000B; upper 28 bits of rdata = 0.
- cpol=1, cpha=1, datalen=7, clkdiv=3, tdata=0x000000C3, miso held 1:
  - sclk idles high; each sclk level lasts 4 clk cycles.
  - mosi changes on falling edges; rdata=0x000000FF.
- tfifo_empty=0 with two words queued (0x5, 0x6), enable=1, datalen=3:
  - Two frames run; ss_n high for at least H+1 cycles between them.
  - rdata sequence (loopback) = 0x5 then 0x6.
- rfifo_full=1 during TAIL, datalen=3: rfifo_wen stays 0, rx_overrun pulses 1 cycle, rdata retains its previous value, and the engine returns to IDLE.
- rst=1 asserted during the 3rd SCLK edge of a datalen=31 frame: same cycle gives ss_n=1, sclk=0, busy=0, mosi=0. After release with enable=0, no tfifo_ren occurs.
